// File: rtl/cpc_io_fifo_bridge_if.sv
// CPC expansion-port and ATMega-side signal bundle for cpc_io_fifo_bridge.
// slave is the bridge's view; master is the view of whatever drives it.
interface cpc_io_fifo_bridge_if #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned FIFO_DEPTH = 16
);
  logic                          i_IORQ;
  logic                          i_RD;
  logic                          i_WR;
  logic [15:0]                   iADR;
  logic [7:0]                    iCPC_DATA;
  logic [7:0]                    oCPC_DATA;
  logic                          oCPC_DATA_OE;
  logic [NUM_CH-1:0]             i_CH_ENABLE;
  logic                          oAVR_VALID;
  logic [7:0]                    oAVR_DATA;
  logic [2:0]                    oAVR_CH;
  logic                          i_AVR_READY;
  logic                          i_REPLY_WE;
  logic [2:0]                    i_REPLY_CH;
  logic [7:0]                    i_REPLY_DATA;
  logic [NUM_CH-1:0]             oREPLY_PENDING;
  logic                          oOVERFLOW;
  logic                          i_OVF_CLR;
  logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL;

  modport slave (
    input  i_IORQ, i_RD, i_WR, iADR, iCPC_DATA, i_CH_ENABLE, i_AVR_READY,
           i_REPLY_WE, i_REPLY_CH, i_REPLY_DATA, i_OVF_CLR,
    output oCPC_DATA, oCPC_DATA_OE, oAVR_VALID, oAVR_DATA, oAVR_CH,
           oREPLY_PENDING, oOVERFLOW, oFIFO_LEVEL
  );

  modport master (
    output i_IORQ, i_RD, i_WR, iADR, iCPC_DATA, i_CH_ENABLE, i_AVR_READY,
           i_REPLY_WE, i_REPLY_CH, i_REPLY_DATA, i_OVF_CLR,
    input  oCPC_DATA, oCPC_DATA_OE, oAVR_VALID, oAVR_DATA, oAVR_CH,
           oREPLY_PENDING, oOVERFLOW, oFIFO_LEVEL
  );
endinterface

// File: rtl/cpc_io_fifo_bridge.sv
// CPC I/O bridge: decoded OUT writes queue in a tagged FIFO for the ATMega, IN reads return
// per-channel reply bytes. Define CPC_STATUS_READ_EN to expose a status byte at STATUS_ADR.
module cpc_io_fifo_bridge #(
  parameter int unsigned          NUM_CH      = 3,
  parameter logic [NUM_CH*16-1:0] ADR_TABLE   = {16'hFBFE, 16'hFAEE, 16'hFBEE},
  parameter int unsigned          FIFO_DEPTH  = 16,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [15:0]          STATUS_ADR  = 16'hFBEF
) (
  input logic                 i_CLK,
  input logic                 i_RESET,
  cpc_io_fifo_bridge_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [SYNC_STAGES-1:0] iorq_sync_q, rd_sync_q, wr_sync_q, settle_q;
  logic                   wr_arm_q, rd_arm_q, wr_prev_q;
  logic                   wr_s, rd_s, rd_act, wr_rise, settled;

  logic                   hit;
  logic [2:0]             hit_ch;

  logic [10:0]            mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic                   head_valid_q, head_valid_d;
  logic [10:0]            head_q, head_d, push_entry;
  logic                   full, pop, push_req, push, drop;
  logic                   ovf_q, ovf_d;

  logic                   oe_q, oe_d, rd_hit_q, rd_hit_d, read_end;
  logic [7:0]             data_q, data_d, reply_byte, status_byte;
  logic                   status_hit;
  logic [2:0]             rd_ch_q;
  logic [7:0]             reply_q [NUM_CH];
  logic [7:0]             reply_d [NUM_CH];
  logic [NUM_CH-1:0]      pend_q, pend_d;

  assign settled = settle_q[SYNC_STAGES-1];
  assign wr_s    = ~iorq_sync_q[SYNC_STAGES-1] & ~wr_sync_q[SYNC_STAGES-1];
  assign rd_s    = ~iorq_sync_q[SYNC_STAGES-1] & ~rd_sync_q[SYNC_STAGES-1];
  // Arming only after a genuinely sampled idle strobe blocks strobes held across reset.
  assign wr_rise = wr_s & ~wr_prev_q & wr_arm_q;
  assign rd_act  = rd_s & rd_arm_q;

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      iorq_sync_q <= '1;
      rd_sync_q   <= '1;
      wr_sync_q   <= '1;
      settle_q    <= '0;
      wr_arm_q    <= 1'b0;
      rd_arm_q    <= 1'b0;
      wr_prev_q   <= 1'b0;
    end else begin
      iorq_sync_q <= {iorq_sync_q[SYNC_STAGES-2:0], bus.i_IORQ};
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], bus.i_RD};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], bus.i_WR};
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      wr_prev_q   <= wr_s;
      if (settled && !wr_s) wr_arm_q <= 1'b1;
      if (settled && !rd_s) rd_arm_q <= 1'b1;
    end
  end

  // Walk downwards so the lowest matching channel is the one left standing.
  always_comb begin
    hit    = 1'b0;
    hit_ch = 3'd0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (bus.iADR == ADR_TABLE[i*16 +: 16] && bus.i_CH_ENABLE[i]) begin
        hit    = 1'b1;
        hit_ch = 3'(i);
      end
    end
  end

  assign push_entry = {hit_ch, bus.iCPC_DATA};
  assign level      = wr_ptr_q - rd_ptr_q;

  always_comb begin
    full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop          = head_valid_q & bus.i_AVR_READY;
    push_req     = wr_rise & hit;
    push         = push_req & (~full | pop);
    drop         = push_req & full & ~pop;
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    head_valid_d = (wr_ptr_d != rd_ptr_d);
    head_d       = '0;
    // A push landing in the slot that becomes the head bypasses the memory.
    if (head_valid_d) begin
      head_d = (push && wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]) ? push_entry
                                                             : mem_q[rd_ptr_d[AW-1:0]];
    end
    ovf_d = (ovf_q & ~bus.i_OVF_CLR) | drop;
  end

  always_ff @(posedge i_CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

`ifdef CPC_STATUS_READ_EN
  logic [4:0] level5;
  assign level5      = 5'(level);
  assign status_hit  = rd_act & (bus.iADR == STATUS_ADR);
  assign status_byte = {ovf_q, full, (level == '0), level5};
`else
  assign status_hit  = 1'b0;
  assign status_byte = 8'h00;
`endif

  always_comb begin
    rd_hit_d   = rd_act & hit;
    reply_byte = 8'h00;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (hit_ch == 3'(i)) reply_byte = reply_q[i];
    end
    oe_d   = rd_hit_d | status_hit;
    data_d = 8'h00;
    if (rd_hit_d)        data_d = reply_byte;
    else if (status_hit) data_d = status_byte;
    read_end = rd_hit_q & ~rd_act;
    reply_d  = reply_q;
    pend_d   = pend_q;
    // Clear before set so a load in the read-end cycle keeps the channel pending.
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (read_end && rd_ch_q == 3'(i)) pend_d[i] = 1'b0;
      if (bus.i_REPLY_WE && bus.i_REPLY_CH == 3'(i)) begin
        reply_d[i] = bus.i_REPLY_DATA;
        pend_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
      ovf_q        <= 1'b0;
      oe_q         <= 1'b0;
      data_q       <= 8'h00;
      rd_hit_q     <= 1'b0;
      rd_ch_q      <= 3'd0;
      reply_q      <= '{default: 8'hFF};
      pend_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      ovf_q        <= ovf_d;
      oe_q         <= oe_d;
      data_q       <= data_d;
      rd_hit_q     <= rd_hit_d;
      if (rd_hit_d) rd_ch_q <= hit_ch;
      reply_q      <= reply_d;
      pend_q       <= pend_d;
    end
  end

  assign bus.oCPC_DATA      = data_q;
  assign bus.oCPC_DATA_OE   = oe_q;
  assign bus.oAVR_VALID     = head_valid_q;
  assign bus.oAVR_DATA      = head_q[7:0];
  assign bus.oAVR_CH        = head_q[10:8];
  assign bus.oREPLY_PENDING = pend_q;
  assign bus.oOVERFLOW      = ovf_q;
  assign bus.oFIFO_LEVEL    = level;
endmodule

// File: tb/tb_cpc_io_fifo_bridge.sv
// Directed bench for cpc_io_fifo_bridge: CPC OUT/IN cycles, FIFO drain, overflow, replies,
// channel enables, optional status port and reset during an active strobe.
module tb_cpc_io_fifo_bridge;
  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned FIFO_DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cpc_io_fifo_bridge_if #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  cpc_io_fifo_bridge #(
    .NUM_CH     (NUM_CH),
    .ADR_TABLE  ({16'hFBFE, 16'hFAEE, 16'hFBEE}),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_STAGES(2),
    .STATUS_ADR (16'hFBEF)
  ) dut (
    .i_CLK  (clk),
    .i_RESET(rst),
    .bus    (bus)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpc_out(input logic [15:0] adr, input logic [7:0] d);
    bus.iADR      = adr;
    bus.iCPC_DATA = d;
    bus.i_IORQ    = 1'b0;
    bus.i_WR      = 1'b0;
    tick(5);
    bus.i_IORQ    = 1'b1;
    bus.i_WR      = 1'b1;
    tick(4);
  endtask

  task automatic cpc_in(input logic [15:0] adr, output logic oe_mid, output logic [7:0] d_mid,
                        output logic oe_any, output logic oe_end);
    bus.iADR   = adr;
    bus.i_IORQ = 1'b0;
    bus.i_RD   = 1'b0;
    oe_any     = 1'b0;
    oe_mid     = 1'b0;
    d_mid      = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        bus.i_IORQ = 1'b1;
        bus.i_RD   = 1'b1;
      end
      tick();
      oe_any |= bus.oCPC_DATA_OE;
      if (i == 3) begin
        oe_mid = bus.oCPC_DATA_OE;
        d_mid  = bus.oCPC_DATA;
      end
    end
    oe_end = bus.oCPC_DATA_OE;
  endtask

  task automatic pop_one();
    bus.i_AVR_READY = 1'b1;
    tick();
    bus.i_AVR_READY = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic       oe_mid, oe_any, oe_end;
    logic [7:0] d_mid;

    rst              = 1'b1;
    bus.i_IORQ       = 1'b1;
    bus.i_RD         = 1'b1;
    bus.i_WR         = 1'b1;
    bus.iADR         = 16'h0000;
    bus.iCPC_DATA    = 8'h00;
    bus.i_CH_ENABLE  = 3'b111;
    bus.i_AVR_READY  = 1'b0;
    bus.i_REPLY_WE   = 1'b0;
    bus.i_REPLY_CH   = 3'd0;
    bus.i_REPLY_DATA = 8'h00;
    bus.i_OVF_CLR    = 1'b0;
    tick(3);
    chk("reset_valid", bus.oAVR_VALID, 1'b0);
    chk("reset_level", bus.oFIFO_LEVEL, 5'd0);
    chk("reset_ovf", bus.oOVERFLOW, 1'b0);
    chk("reset_oe", bus.oCPC_DATA_OE, 1'b0);
    chk("reset_pending", bus.oREPLY_PENDING, 3'b000);
    rst = 1'b0;
    tick(5);

    // Unloaded reply register reads back its reset value.
    cpc_in(16'hFBFE, oe_mid, d_mid, oe_any, oe_end);
    chk("reply_reset_oe", oe_mid, 1'b1);
    chk("reply_reset_data", d_mid, 8'hFF);
    chk("reply_reset_oe_end", oe_end, 1'b0);

    // OUT &FBEE,&41 with push latency.
    bus.iADR      = 16'hFBEE;
    bus.iCPC_DATA = 8'h41;
    bus.i_IORQ    = 1'b0;
    bus.i_WR      = 1'b0;
    tick(2);
    chk("lat_valid_early", bus.oAVR_VALID, 1'b0);
    tick(1);
    chk("lat_valid", bus.oAVR_VALID, 1'b1);
    chk("out41_data", bus.oAVR_DATA, 8'h41);
    chk("out41_ch", bus.oAVR_CH, 3'd0);
    chk("out41_level", bus.oFIFO_LEVEL, 5'd1);
    tick(2);
    bus.i_IORQ = 1'b1;
    bus.i_WR   = 1'b1;
    tick(4);
    chk("out41_single_push", bus.oFIFO_LEVEL, 5'd1);
    pop_one();
    chk("pop_valid", bus.oAVR_VALID, 1'b0);
    chk("pop_level", bus.oFIFO_LEVEL, 5'd0);
    pop_one();
    chk("empty_ready_level", bus.oFIFO_LEVEL, 5'd0);

    // 17 writes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) cpc_out(16'hFBFE, 8'(8'h10 + i));
    chk("ovf_level", bus.oFIFO_LEVEL, 5'd16);
    chk("ovf_flag", bus.oOVERFLOW, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", bus.oAVR_VALID, 1'b1);
      chk("drain_data", bus.oAVR_DATA, 8'(8'h10 + i));
      chk("drain_ch", bus.oAVR_CH, 3'd2);
      pop_one();
    end
    chk("drain_17th_absent", bus.oAVR_VALID, 1'b0);
    chk("ovf_sticky", bus.oOVERFLOW, 1'b1);
    bus.i_OVF_CLR = 1'b1;
    tick();
    bus.i_OVF_CLR = 1'b0;
    chk("ovf_clear", bus.oOVERFLOW, 1'b0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 16; i++) cpc_out(16'hFBEE, 8'(8'h20 + i));
    chk("full_level", bus.oFIFO_LEVEL, 5'd16);
    bus.iADR      = 16'hFBEE;
    bus.iCPC_DATA = 8'hA5;
    bus.i_IORQ    = 1'b0;
    bus.i_WR      = 1'b0;
    tick(2);
    bus.i_AVR_READY = 1'b1;
    tick(1);
    bus.i_AVR_READY = 1'b0;
    chk("pushpop_level", bus.oFIFO_LEVEL, 5'd16);
    chk("pushpop_ovf", bus.oOVERFLOW, 1'b0);
    chk("pushpop_head", bus.oAVR_DATA, 8'h21);
    tick(2);
    bus.i_IORQ = 1'b1;
    bus.i_WR   = 1'b1;
    tick(4);
    for (int i = 0; i < 16; i++) begin
      chk("pushpop_drain", bus.oAVR_DATA, (i < 15) ? 8'(8'h21 + i) : 8'hA5);
      pop_one();
    end
    chk("pushpop_empty", bus.oAVR_VALID, 1'b0);

    // Reply load and CPC IN on channel 1.
    bus.i_REPLY_WE   = 1'b1;
    bus.i_REPLY_CH   = 3'd1;
    bus.i_REPLY_DATA = 8'h80;
    tick();
    bus.i_REPLY_CH   = 3'd5;
    bus.i_REPLY_DATA = 8'h11;
    tick();
    bus.i_REPLY_WE = 1'b0;
    chk("reply_pending_set", bus.oREPLY_PENDING, 3'b010);
    cpc_in(16'hFAEE, oe_mid, d_mid, oe_any, oe_end);
    chk("reply_oe", oe_mid, 1'b1);
    chk("reply_data", d_mid, 8'h80);
    chk("reply_oe_drop", oe_end, 1'b0);
    chk("reply_pending_clr", bus.oREPLY_PENDING, 3'b000);

    // Disabled channel 0.
    bus.i_CH_ENABLE = 3'b110;
    cpc_out(16'hFBEE, 8'h55);
    chk("disabled_no_push", bus.oFIFO_LEVEL, 5'd0);
    chk("disabled_valid", bus.oAVR_VALID, 1'b0);
    cpc_in(16'hFBEE, oe_mid, d_mid, oe_any, oe_end);
    chk("disabled_no_oe", oe_any, 1'b0);
    bus.i_CH_ENABLE = 3'b111;

    // Status port with three bytes queued.
    for (int i = 0; i < 3; i++) cpc_out(16'hFBEE, 8'(8'h30 + i));
    cpc_in(16'hFBEF, oe_mid, d_mid, oe_any, oe_end);
`ifdef CPC_STATUS_READ_EN
    chk("status_oe", oe_mid, 1'b1);
    chk("status_data", d_mid, 8'h03);
`else
    chk("status_no_oe", oe_any, 1'b0);
`endif
    chk("status_no_side_effect", bus.oFIFO_LEVEL, 5'd3);

    // Reset during an active read, strobe held across reset release.
    bus.iADR   = 16'hFBFE;
    bus.i_IORQ = 1'b0;
    bus.i_RD   = 1'b0;
    tick(4);
    chk("midread_oe", bus.oCPC_DATA_OE, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_oe_drop", bus.oCPC_DATA_OE, 1'b0);
    chk("rst_flush", bus.oFIFO_LEVEL, 5'd0);
    rst    = 1'b0;
    oe_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      oe_any |= bus.oCPC_DATA_OE;
    end
    chk("held_strobe_no_oe", oe_any, 1'b0);
    bus.i_IORQ = 1'b1;
    bus.i_RD   = 1'b1;
    tick(4);
    cpc_in(16'hFBFE, oe_mid, d_mid, oe_any, oe_end);
    chk("rearm_oe", oe_mid, 1'b1);
    chk("rearm_data", d_mid, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpc_io_fifo_bridge.md
Name: cpc_io_fifo_bridge

Overview:
- Synchronous, parametrised CPC expansion-port I/O bridge for the LambdaSpeak CPLD/FPGA.
- Decodes up to NUM_CH CPC I/O addresses and buffers CPC OUT writes in a FIFO, tagged with the channel index, for the ATMega to drain via a valid/ready handshake.
- Serves CPC IN reads from per-channel reply registers that the ATMega loads.
- Replaces single-byte edge latches with clocked capture, backpressure and overflow reporting.

Parameters:
- NUM_CH, 3: number of decoded I/O channels (1..8).
- ADR_TABLE, {16'hFBFE,16'hFAEE,16'hFBEE}: NUM_CH x 16-bit packed addresses; channel 0 in the LSBs.
- FIFO_DEPTH, 16: write FIFO depth; power of two, 2..64.
- SYNC_STAGES, 2: synchroniser flops on i_IORQ/i_RD/i_WR (2 or 3).
- STATUS_ADR, 16'hFBEF: status port address; used only with CPC_STATUS_READ_EN.

Ports:
- i_CLK  in  1  system clock, >=16 MHz.
- i_RESET  in  1  synchronous reset, active high.
- i_IORQ  in  1  CPC /IORQ, active low, asynchronous.
- i_RD  in  1  CPC /RD, active low.
- i_WR  in  1  CPC /WR, active low.
- iADR  in  16  CPC address bus.
- iCPC_DATA  in  8  CPC data bus, input side.
- oCPC_DATA  out  8  data driven to CPC.
- oCPC_DATA_OE  out  1  tristate enable for the CPC data bus.
- i_CH_ENABLE  in  NUM_CH  per-channel enable; mode decode is done outside this block.
- oAVR_VALID  out  1  FIFO head valid.
- oAVR_DATA  out  8  FIFO head data.
- oAVR_CH  out  3  FIFO head channel index.
- i_AVR_READY  in  1  ATMega accepts the head.
- i_REPLY_WE  in  1  load a reply register.
- i_REPLY_CH  in  3  reply channel index.
- i_REPLY_DATA  in  8  reply byte.
- oREPLY_PENDING  out  NUM_CH  reply loaded but not yet read by the CPC.
- oOVERFLOW  out  1  sticky: a write was dropped.
- i_OVF_CLR  in  1  clears oOVERFLOW.
- oFIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: all outputs 0, FIFO empty, reply registers 8'hFF, synchronisers set to the inactive-high level.
- Strobes: wr_s = sync(~i_IORQ & ~i_WR); rd_s = sync(~i_IORQ & ~i_RD). wr_rise is the first cycle wr_s is high.
- Decode: a channel matches when iADR == ADR_TABLE[ch] and i_CH_ENABLE[ch] = 1. The lowest index wins on a duplicate address.
- Write capture: on wr_rise with a match, sample iCPC_DATA and the channel index in that cycle and push {ch, data}. Latency from the first synchronised strobe cycle to oAVR_VALID is 1 clk.
- Write with no match: ignored.
- Full FIFO: the push is dropped and oOVERFLOW is set. If a pop happens in the same cycle, the push is accepted and nothing is dropped.
- Pop: occurs when oAVR_VALID & i_AVR_READY. Head outputs are registered and update the cycle after the pop.
- Empty FIFO: oAVR_VALID = 0, and i_AVR_READY has no effect.
- Read: while rd_s is high and a channel matches, oCPC_DATA_OE = 1 and oCPC_DATA = reply[ch]. OE drops within 1 clk of rd_s falling.
- Read side effect: on the rd_s falling edge of a matched read, clear oREPLY_PENDING[ch].
- Reply load: i_REPLY_WE writes reply[i_REPLY_CH] and sets its pending bit. i_REPLY_CH >= NUM_CH is ignored.
- Reply load and read-end in the same cycle on the same channel: the load wins (pending stays 1).
- Overflow: i_OVF_CLR and a drop in the same cycle leave oOVERFLOW = 1.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH. Full when the MSBs differ and the LSBs are equal.
- Reset asserted mid-transfer: the FIFO is flushed and OE drops the next cycle. A CPC strobe still active after reset release does not generate a write or read until the strobe has been seen inactive.

Optional Feature:
- CPC_STATUS_READ_EN defined: a CPC read at STATUS_ADR drives {oOVERFLOW, full, empty, oFIFO_LEVEL[4:0]} with OE asserted. The status port is always enabled and has no side effects.
- Not defined: STATUS_ADR is not decoded and the block never drives on it.

Test Plan:
- Reset, then CPC OUT &FBEE,&41 -> oAVR_VALID = 1, oAVR_DATA = 8'h41, oAVR_CH = 0. Pop with ready -> valid = 0.
- 17 OUTs to &FBFE with i_AVR_READY = 0 (depth 16) -> level 16, oOVERFLOW = 1, first 16 bytes drained in order, 17th absent. i_OVF_CLR -> 0.
- FIFO full, CPC write in the same cycle as a pop -> no overflow, level stays 16.
- i_REPLY_WE ch1 = 8'h80, then CPC IN &FAEE -> OE high, data 8'h80. oREPLY_PENDING[1] goes 1 -> 0 after the read ends.
- i_CH_ENABLE = 3'b110, OUT &FBEE,&55 and IN &FBEE -> no push, OE never asserted.
- CPC_STATUS_READ_EN defined, 3 bytes queued -> IN &FBEF returns 8'h03. Undefined -> OE = 0.
